pipe_flow_ctrl: RTL and testbench

Parametrised pipeline flow controller for the next-generation CPU core. It generalises the fixed five-stage valid/allowin chain, currently hand-wired across the stage modules, to `STAGES` stages, and adds a single-cycle global flush for exceptions and eret. It also tracks outstanding instruction-fetch requests on a split-handshake (req/addr_ok/data_ok) memory interface, so that responses issued before a flush are discarded. It sits beside the stage modules in the CPU top; the stages keep their datapath registers and take latch enables from this block.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/fetch_outs_tracker.sv | 54 +++++
 rtl/pipe_flow_ctrl.sv | 82 ++++++++
 tb/tb_pipe_flow_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline constants: stage indices used by the CPU top and stage modules,
// plus default sizing for the flow controller.
package pipe_pkg;

    localparam int STG_IF  = 0;
    localparam int STG_ID  = 1;
    localparam int STG_EX  = 2;
    localparam int STG_MEM = 3;
    localparam int STG_WB  = 4;

    localparam int NUM_STAGES_DEF = STG_WB + 1;
    localparam int MAX_OUTS_DEF   = 2;

endpackage

// File: rtl/fetch_outs_tracker.sv
// Counts in-flight instruction-fetch requests and marks responses that belong
// to requests issued before the most recent flush.
module fetch_outs_tracker
    import pipe_pkg::*;
#(
    parameter int MAX_OUTS = MAX_OUTS_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            fetch_req_fire,
    input  logic                            fetch_resp_fire,
    output logic                            fetch_req_allow,
    output logic                            fetch_resp_drop,
    output logic [$clog2(MAX_OUTS+1)-1:0]   fetch_outstanding
);

    localparam int CW = $clog2(MAX_OUTS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] drop_q, drop_d;

    always_comb begin
        cnt_d = cnt_q;
        // A response with nothing outstanding is an upstream error; hold at zero.
        if (fetch_req_fire && !fetch_resp_fire)
            cnt_d = cnt_q + 1'b1;
        else if (!fetch_req_fire && fetch_resp_fire && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;

        fetch_resp_drop = fetch_resp_fire & ((drop_q != '0) | flush);

        // On flush everything still in flight afterwards becomes stale.
        drop_d = drop_q;
        if (flush)
            drop_d = cnt_d;
        else if (fetch_resp_drop)
            drop_d = drop_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            drop_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign fetch_req_allow   = (cnt_q != CW'(MAX_OUTS));
    assign fetch_outstanding = cnt_q;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Parametrised valid/allowin chain for an in-order pipeline with a one-cycle
// global flush, plus tracking of outstanding split-handshake fetch requests.
module pipe_flow_ctrl
    import pipe_pkg::*;
#(
    parameter int STAGES   = NUM_STAGES_DEF,
    parameter int MAX_OUTS = MAX_OUTS_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_allowin,
    input  logic [STAGES-1:0]               ready_go,
    input  logic                            out_ready,
    input  logic                            flush,
    output logic [STAGES-1:0]               stage_valid,
    output logic [STAGES-1:0]               stage_allowin,
    output logic [STAGES-1:0]               stage_load,
    output logic                            out_fire,
    input  logic                            fetch_req_fire,
    input  logic                            fetch_resp_fire,
    output logic                            fetch_req_allow,
    output logic                            fetch_resp_drop,
    output logic [$clog2(MAX_OUTS+1)-1:0]   fetch_outstanding
);

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES:0]   allow;
    logic [STAGES-1:0] go_in;   // go_in[i] is go of the stage feeding stage i

    // Allowin ripples from the sink back to IF within the same cycle.
    always_comb begin
        allow         = '0;
        allow[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--)
            allow[i] = !valid_q[i] | (ready_go[i] & allow[i+1]);
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign go_in[g] = in_valid & !flush;
        end else begin : g_body
            assign go_in[g] = valid_q[g-1] & ready_go[g-1] & !flush;
        end
        assign stage_load[g] = allow[g] & go_in[g];
    end

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < STAGES; i++)
                if (allow[i]) valid_d[i] = go_in[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    assign stage_valid   = valid_q;
    assign stage_allowin = allow[STAGES-1:0];
    assign in_allowin    = allow[STG_IF];
    // The flushing instruction itself retires, so flush does not gate this.
    assign out_fire      = valid_q[STAGES-1] & ready_go[STAGES-1] & out_ready;

    fetch_outs_tracker #(
        .MAX_OUTS (MAX_OUTS)
    ) u_fetch_outs_tracker (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .fetch_req_fire    (fetch_req_fire),
        .fetch_resp_fire   (fetch_resp_fire),
        .fetch_req_allow   (fetch_req_allow),
        .fetch_resp_drop   (fetch_resp_drop),
        .fetch_outstanding (fetch_outstanding)
    );

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed bench for pipe_flow_ctrl: each cycle's hand-computed expectation is
// queued by the stimulus and checked by an independent monitor on the falling edge.
module tb_pipe_flow_ctrl;
    import pipe_pkg::*;

    localparam int S = 5;
    localparam int M = 2;
    localparam logic [4:0] F = 5'b11111;

    logic         clk = 1'b0;
    logic         reset, in_valid, out_ready, flush;
    logic [S-1:0] ready_go;
    logic         fetch_req_fire, fetch_resp_fire;
    logic         in_allowin, out_fire, fetch_req_allow, fetch_resp_drop;
    logic [S-1:0] stage_valid, stage_allowin, stage_load;
    logic [1:0]   fetch_outstanding;

    always #5 clk = ~clk;

    pipe_flow_ctrl #(.STAGES(S), .MAX_OUTS(M)) dut (
        .clk               (clk),
        .reset             (reset),
        .in_valid          (in_valid),
        .in_allowin        (in_allowin),
        .ready_go          (ready_go),
        .out_ready         (out_ready),
        .flush             (flush),
        .stage_valid       (stage_valid),
        .stage_allowin     (stage_allowin),
        .stage_load        (stage_load),
        .out_fire          (out_fire),
        .fetch_req_fire    (fetch_req_fire),
        .fetch_resp_fire   (fetch_resp_fire),
        .fetch_req_allow   (fetch_req_allow),
        .fetch_resp_drop   (fetch_resp_drop),
        .fetch_outstanding (fetch_outstanding)
    );

    typedef struct {
        logic [4:0] sv, al, ld;
        logic       of, ra, rd;
        logic [1:0] outs;
        int         idx;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_vec = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    // One cycle: drive inputs, queue the expected combinational/registered outputs.
    task automatic v(input logic rst, input logic iv, input logic [4:0] rg, input logic ordy,
                     input logic fl, input logic rqf, input logic rsf,
                     input logic [4:0] sv, input logic [4:0] al, input logic [4:0] ld,
                     input logic of, input logic ra, input logic rd, input logic [1:0] outs);
        exp_t e;
        reset = rst; in_valid = iv; ready_go = rg; out_ready = ordy;
        flush = fl; fetch_req_fire = rqf; fetch_resp_fire = rsf;
        e.sv = sv; e.al = al; e.ld = ld; e.of = of; e.ra = ra; e.rd = rd;
        e.outs = outs; e.idx = n_vec;
        n_vec++;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            chk("stage_valid",       e.idx, 32'(stage_valid),       32'(e.sv));
            chk("stage_allowin",     e.idx, 32'(stage_allowin),     32'(e.al));
            chk("in_allowin",        e.idx, 32'(in_allowin),        32'(e.al[0]));
            chk("stage_load",        e.idx, 32'(stage_load),        32'(e.ld));
            chk("out_fire",          e.idx, 32'(out_fire),          32'(e.of));
            chk("fetch_req_allow",   e.idx, 32'(fetch_req_allow),   32'(e.ra));
            chk("fetch_resp_drop",   e.idx, 32'(fetch_resp_drop),   32'(e.rd));
            chk("fetch_outstanding", e.idx, 32'(fetch_outstanding), 32'(e.outs));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; ready_go = F; out_ready = 1'b1;
        flush = 1'b0; fetch_req_fire = 1'b0; fetch_resp_fire = 1'b0;
        @(posedge clk); #1;
        // reset state
        //rst iv rg ordy fl rq rs   sv        al        ld        of ra rd outs
        v(1, 0, F, 1, 0, 0, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        // 7 back-to-back instructions, first retire at cycle 5
        v(0, 1, F, 1, 0, 0, 0, 5'b00000, F,        5'b00001, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00001, F,        5'b00011, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00011, F,        5'b00111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00111, F,        5'b01111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b01111, F,        5'b11111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b11111, F,        5'b11111, 1, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b11111, F,        5'b11111, 1, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b11111, F,        5'b11110, 1, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b11110, F,        5'b11100, 1, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b11100, F,        5'b11000, 1, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b11000, F,        5'b10000, 1, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b10000, F,        5'b00000, 1, 1, 0, 0);
        // fill, then stall EX for 3 cycles
        v(0, 1, F, 1, 0, 0, 0, 5'b00000, F,        5'b00001, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00001, F,        5'b00011, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00011, F,        5'b00111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00111, F,        5'b01111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b01111, F,        5'b11111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b11111, F,        5'b11111, 1, 1, 0, 0);
        v(0, 1, 5'b11011, 1, 0, 0, 0, 5'b11111, 5'b11000, 5'b10000, 1, 1, 0, 0);
        v(0, 1, 5'b11011, 1, 0, 0, 0, 5'b10111, 5'b11000, 5'b00000, 1, 1, 0, 0);
        v(0, 1, 5'b11011, 1, 0, 0, 0, 5'b00111, 5'b11000, 5'b00000, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00111, F,        5'b01111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b01111, F,        5'b11111, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b11111, F,        5'b11111, 1, 1, 0, 0);
        // sink not ready: whole full pipe holds
        v(0, 1, F, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b00000, 0, 1, 0, 0);
        // flush with full pipe and in_valid high
        v(0, 1, F, 1, 1, 0, 0, 5'b11111, F,        5'b00000, 1, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00000, F,        5'b00001, 0, 1, 0, 0);
        v(0, 1, F, 1, 0, 0, 0, 5'b00001, F,        5'b00011, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b00011, F,        5'b00110, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b00110, F,        5'b01100, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b01100, F,        5'b11000, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b11000, F,        5'b10000, 1, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b10000, F,        5'b00000, 1, 1, 0, 0);
        // two requests saturate, flush, both responses dropped, fresh one kept
        v(0, 0, F, 1, 0, 1, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 1, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 1);
        v(0, 0, F, 1, 0, 0, 0, 5'b00000, F,        5'b00000, 0, 0, 0, 2);
        v(0, 0, F, 1, 1, 0, 0, 5'b00000, F,        5'b00000, 0, 0, 0, 2);
        v(0, 0, F, 1, 0, 0, 1, 5'b00000, F,        5'b00000, 0, 0, 1, 2);
        v(0, 0, F, 1, 0, 0, 1, 5'b00000, F,        5'b00000, 0, 1, 1, 1);
        v(0, 0, F, 1, 0, 1, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 1, 5'b00000, F,        5'b00000, 0, 1, 0, 1);
        // flush + req + resp together with cnt=1
        v(0, 0, F, 1, 0, 1, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        v(0, 0, F, 1, 1, 1, 1, 5'b00000, F,        5'b00000, 0, 1, 1, 1);
        v(0, 0, F, 1, 0, 0, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 1);
        v(0, 0, F, 1, 0, 0, 1, 5'b00000, F,        5'b00000, 0, 1, 1, 1);
        // spurious response with nothing outstanding: count holds at 0
        v(0, 0, F, 1, 0, 0, 1, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        // drop=2, pipe half full, then reset
        v(0, 0, F, 1, 0, 1, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 1, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 1);
        v(0, 0, F, 1, 1, 0, 0, 5'b00000, F,        5'b00000, 0, 0, 0, 2);
        v(0, 1, F, 1, 0, 0, 0, 5'b00000, F,        5'b00001, 0, 0, 0, 2);
        v(0, 1, F, 1, 0, 0, 0, 5'b00001, F,        5'b00011, 0, 0, 0, 2);
        v(1, 1, F, 1, 0, 0, 0, 5'b00011, F,        5'b00111, 0, 0, 0, 2);
        v(0, 0, F, 1, 0, 0, 0, 5'b00000, F,        5'b00000, 0, 1, 0, 0);
        v(0, 0, F, 1, 0, 0, 1, 5'b00000, F,        5'b00000, 0, 1, 0, 0);

        chk("queue_drained", n_vec, 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
